// File: rtl/muldiv_unit_pkg.sv
// Shared opcode package: M-extension op encoding, unit FSM states and decode helpers.
package muldiv_unit_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        MdMul    = 3'd0,
        MdMulh   = 3'd1,
        MdMulhsu = 3'd2,
        MdMulhu  = 3'd3,
        MdDiv    = 3'd4,
        MdDivu   = 3'd5,
        MdRem    = 3'd6,
        MdRemu   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } md_state_e;

    function automatic logic md_is_div(md_op_e op);
        return op[2];
    endfunction

    // rs2 selects which operand is asked about: 0 = rs1 (a), 1 = rs2 (b).
    function automatic logic md_is_signed(md_op_e op, logic rs2);
        case (op)
            MdMulh, MdDiv, MdRem: return 1'b1;
            MdMulhsu:             return !rs2;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational conditional two's-complement negate; doubles as abs() when neg = sign bit.
module md_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit, one result bit per cycle, valid/ready on both sides.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    md_state_e           state_q;
    md_op_e              op_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_res_q;
    logic                neg_rem_q;

    md_op_e              op_in;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_trial;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     div_sel, div_fix;
    logic                div_neg;
    logic [XLEN-1:0]     fix_result;

    assign op_in = md_op_e'(in_op);
    assign a_neg = md_is_signed(op_in, 1'b0) & in_a[XLEN-1];
    assign b_neg = md_is_signed(op_in, 1'b1) & in_b[XLEN-1];

    md_sign_fix #(.W(XLEN)) u_abs_a (
        .value  (in_a),
        .neg    (a_neg),
        .result (a_mag)
    );

    md_sign_fix #(.W(XLEN)) u_abs_b (
        .value  (in_b),
        .neg    (b_neg),
        .result (b_mag)
    );

    assign in_ready  = (state_q == StIdle) && !flush;
    assign out_valid = (state_q == StDone);

    assign div_zero = md_is_div(op_in) && (in_b == '0);
    assign div_ovf  = ((op_in == MdDiv) || (op_in == MdRem)) &&
                      (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);

    // op[1] distinguishes REM/REMU from DIV/DIVU
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = in_op[1] ? in_a : '1;
        end else if (div_ovf) begin
            special_res = in_op[1] ? '0 : in_a;
        end
    end

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    md_sign_fix #(.W(2*XLEN)) u_fix_prod (
        .value  (acc_q),
        .neg    (neg_res_q),
        .result (prod_fix)
    );

    assign div_sel = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign div_neg = op_q[1] ? neg_rem_q : neg_res_q;

    md_sign_fix #(.W(XLEN)) u_fix_div (
        .value  (div_sel),
        .neg    (div_neg),
        .result (div_fix)
    );

    always_comb begin
        fix_result = div_fix;
        case (op_q)
            MdMul:                     fix_result = prod_fix[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: fix_result = prod_fix[2*XLEN-1:XLEN];
            default:                   fix_result = div_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= MdMul;
            cnt_q      <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q      <= op_in;
                        out_tag   <= in_tag;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (div_zero || div_ovf) begin
                            out_result <= special_res;
                            state_q    <= StDone;
                        end else begin
                            cnt_q   <= CNT_W'(XLEN - 1);
                            opnd_q  <= md_is_div(op_in) ? b_mag : a_mag;
                            acc_q   <= {{XLEN{1'b0}}, md_is_div(op_in) ? a_mag : b_mag};
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= md_is_div(op_q) ? div_next : mul_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    out_result <= fix_result;
                    state_q    <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN = 32 with hand-computed results.
module tb_muldiv_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'd0;
    logic [XLEN-1:0]  in_a = '0;
    logic [XLEN-1:0]  in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    int total = 0;
    int bad = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counted so that a result registered at the accept edge reads as 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        send(op, a, b, 5'd0);
        wait_valid(lat);
        check_eq({name, " valid"}, 32'(out_valid), 32'd1);
        check_eq({name, " result"}, out_result, exp);
        if (exp_lat != 0) check_eq({name, " latency"}, 32'(lat), 32'(exp_lat));
        take();
    endtask

    initial begin
        int lat;
        int seen;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst in_ready", 32'(in_ready), 32'd1);
        check_eq("rst out_valid", 32'(out_valid), 32'd0);
        check_eq("rst out_result", out_result, 32'd0);
        check_eq("rst out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // op codes: MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7
        do_op("mul 7*-3",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        do_op("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        do_op("mulhu",        3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        do_op("mulhsu -1*2",  3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 0);
        do_op("divu 100/7",   3'd5, 32'd100,      32'd7,        32'd14,        34);
        do_op("remu 100%7",   3'd7, 32'd100,      32'd7,        32'd2,         0);
        do_op("div -100/7",   3'd4, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 0);
        do_op("rem -100%7",   3'd6, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 0);
        do_op("div 5/0",      3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        do_op("rem 5/0",      3'd6, 32'd5,        32'd0,        32'd5,         1);
        do_op("divu 5/0",     3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        do_op("div ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

        // Flush mid-CALC: the killed result must never appear.
        send(3'd5, 32'd200, 32'd3, 5'd2);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check_eq("flush in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        check_eq("flush no valid", 32'(seen), 32'd0);
        check_eq("flush idle", 32'(in_ready), 32'd1);

        send(3'd5, 32'd9, 32'd3, 5'h1F);
        wait_valid(lat);
        check_eq("post-flush result", out_result, 32'd3);
        check_eq("post-flush tag", 32'(out_tag), 32'h1F);
        take();

        // Flush wins over a simultaneous request in IDLE.
        in_op    = 3'd5;
        in_a     = 32'd9;
        in_b     = 32'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check_eq("flush vs valid ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check_eq("flush vs valid idle", 32'(in_ready), 32'd1);
        check_eq("flush vs valid out", 32'(out_valid), 32'd0);

        // Backpressure in DONE.
        send(3'd5, 32'd100, 32'd7, 5'h0A);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold valid", 32'(out_valid), 32'd1);
            check_eq("hold result", out_result, 32'd14);
            check_eq("hold tag", 32'(out_tag), 32'h0A);
            check_eq("hold in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        take();
        check_eq("release in_ready", 32'(in_ready), 32'd1);
        check_eq("release out_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
